// File: rtl/modport_fifo.sv
// Single-clock synchronous FIFO with registered read data and occupancy-decoded
// full / empty / almost-full / almost-empty flags.
module modport_fifo #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 16,
   parameter int ALM_FULL_TH  = 14,
   parameter int ALM_EMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_wrdata,
   input  logic              i_wren,
   input  logic              i_rden,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_alm_full,
   output logic              o_alm_empty,
   output logic [DATA_W-1:0] o_rddata
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic [CW-1:0]     count_nxt_s;
   logic [DATA_W-1:0] rddata_r;
   logic              wr_ok_s;
   logic              rd_ok_s;
   logic              full_s;
   logic              empty_s;

   // Flags come straight from the registered occupancy so they describe the state after the last edge.
   assign full_s      = (count_r == CW'(DEPTH));
   assign empty_s     = (count_r == CW'(0));
   assign o_full      = full_s;
   assign o_empty     = empty_s;
   assign o_alm_full  = (count_r >= CW'(ALM_FULL_TH));
   assign o_alm_empty = (count_r <= CW'(ALM_EMPTY_TH));
   assign o_rddata    = rddata_r;

   // Request acceptance and next occupancy; requests are ignored while reset is high.
   always_comb begin
      wr_ok_s     = 1'b0;
      rd_ok_s     = 1'b0;
      count_nxt_s = count_r;
      if (reset) begin
         wr_ok_s = 1'b0;
         rd_ok_s = 1'b0;
      end else begin
         wr_ok_s = i_wren & ~full_s;
         rd_ok_s = i_rden & ~empty_s;
      end
      case ({wr_ok_s, rd_ok_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy and read data register; pointers wrap naturally at power-of-two depth.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         rddata_r <= {DATA_W{1'b0}};
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (rd_ok_s) begin
            rddata_r <= mem_r[rd_ptr_r];
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   // Storage array is left uncleared; stale entries are unreachable once the pointers reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= i_wrdata;
      end
   end

endmodule

// File: tb/tb_modport_fifo.sv
// Self-checking bench for modport_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_modport_fifo;

   localparam int DW = 8;
   localparam int DP = 16;

   logic          clk;
   logic          reset;
   logic [DW-1:0] i_wrdata;
   logic          i_wren;
   logic          i_rden;
   logic          o_full;
   logic          o_empty;
   logic          o_alm_full;
   logic          o_alm_empty;
   logic [DW-1:0] o_rddata;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_rd;

   modport_fifo #(.DATA_W(DW), .DEPTH(DP), .ALM_FULL_TH(14), .ALM_EMPTY_TH(2)) dut (
      .clk(clk), .reset(reset), .i_wrdata(i_wrdata), .i_wren(i_wren), .i_rden(i_rden),
      .o_full(o_full), .o_empty(o_empty), .o_alm_full(o_alm_full),
      .o_alm_empty(o_alm_empty), .o_rddata(o_rddata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock with the given requests; the model follows the FIFO rules at the same edge.
   task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d, input logic rst);
      bit was_full;
      bit was_empty;
      reset    = rst;
      i_wren   = wr;
      i_rden   = rd;
      i_wrdata = d;
      @(posedge clk);
      #1;
      if (rst) begin
         model_q.delete();
         model_rd = 8'h00;
      end else begin
         was_full  = (model_q.size() == DP);
         was_empty = (model_q.size() == 0);
         if (rd && !was_empty) model_rd = model_q.pop_front();
         if (wr && !was_full) model_q.push_back(d);
      end
      reset  = 1'b0;
      i_wren = 1'b0;
      i_rden = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b1, 8'h77, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", o_empty); end
      n_cmp++; if (o_alm_empty !== 1'b1) begin n_err++; $display("FAIL reset_alm_empty: got %b want 1", o_alm_empty); end
      n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", o_full); end
      n_cmp++; if (o_alm_full !== 1'b0) begin n_err++; $display("FAIL reset_alm_full: got %b want 0", o_alm_full); end
      n_cmp++; if (o_rddata !== 8'h00) begin n_err++; $display("FAIL reset_rddata: got %h want 00", o_rddata); end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b0, 8'(i), 1'b0);
         n_cmp++; if (o_full !== (i == 16)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, o_full, (i == 16)); end
         n_cmp++; if (o_alm_full !== (i >= 14)) begin n_err++; $display("FAIL fill_alm_full[%0d]: got %b want %b", i, o_alm_full, (i >= 14)); end
         n_cmp++; if (o_empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d]: got %b want 0", i, o_empty); end
         n_cmp++; if (o_alm_empty !== (i <= 2)) begin n_err++; $display("FAIL fill_alm_empty[%0d]: got %b want %b", i, o_alm_empty, (i <= 2)); end
      end
   endtask

   task automatic test_overflow_drain();
      cycle(1'b1, 1'b0, 8'hAA, 1'b0);
      n_cmp++; if (o_full !== 1'b1) begin n_err++; $display("FAIL overflow_full: got %b want 1", o_full); end
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0);
         n_cmp++; if (o_rddata !== 8'(i)) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, o_rddata, 8'(i)); end
         n_cmp++; if (o_alm_empty !== (16 - i <= 2)) begin n_err++; $display("FAIL drain_alm_empty[%0d]: got %b want %b", i, o_alm_empty, (16 - i <= 2)); end
      end
      n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", o_empty); end
   endtask

   task automatic test_read_empty();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0);
         n_cmp++; if (o_rddata !== 8'h10) begin n_err++; $display("FAIL rdempty_hold[%0d]: got %h want 10", i, o_rddata); end
         n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL rdempty_empty[%0d]: got %b want 1", i, o_empty); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
         n_cmp++; if (o_rddata !== model_rd) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, o_rddata, model_rd); end
         n_cmp++; if ({o_full, o_empty, o_alm_full, o_alm_empty} !== 4'b0000 || model_q.size() != 8) begin
            n_err++; $display("FAIL b2b_flags[%0d]: got %b want 0000", i, {o_full, o_empty, o_alm_full, o_alm_empty});
         end
      end
   endtask

   task automatic test_full_simul();
      logic [DW-1:0] oldest;
      while (model_q.size() < DP) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
      n_cmp++; if (o_full !== 1'b1) begin n_err++; $display("FAIL fsim_prefull: got %b want 1", o_full); end
      oldest = model_q[0];
      cycle(1'b1, 1'b1, 8'h55, 1'b0);
      n_cmp++; if (o_rddata !== oldest) begin n_err++; $display("FAIL fsim_data: got %h want %h", o_rddata, oldest); end
      n_cmp++; if (o_full !== 1'b0 || o_alm_full !== 1'b1) begin n_err++; $display("FAIL fsim_flags: got full=%b alm=%b want 0/1", o_full, o_alm_full); end
      for (int i = 0; i < 15; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0);
         n_cmp++; if (o_rddata !== model_rd) begin n_err++; $display("FAIL fsim_drain[%0d]: got %h want %h", i, o_rddata, model_rd); end
      end
      n_cmp++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL fsim_empty: got %b want 1 (15 entries expected)", o_empty); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
      cycle(1'b1, 1'b1, 8'hC5, 1'b0);
      n_cmp++; if (o_rddata !== 8'hC0) begin n_err++; $display("FAIL rmid_pre: got %h want c0", o_rddata); end
      cycle(1'b1, 1'b1, 8'hEE, 1'b1);
      n_cmp++; if (o_empty !== 1'b1 || o_alm_empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b/%b want 1/1", o_empty, o_alm_empty); end
      n_cmp++; if (o_rddata !== 8'h00) begin n_err++; $display("FAIL rmid_rddata: got %h want 00", o_rddata); end
      cycle(1'b1, 1'b0, 8'h3C, 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      n_cmp++; if (o_rddata !== 8'h3C) begin n_err++; $display("FAIL rmid_new: got %h want 3c", o_rddata); end
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      n_cmp++; if (o_rddata !== 8'h3C || o_empty !== 1'b1) begin n_err++; $display("FAIL rmid_after: got %h/%b want 3c/1", o_rddata, o_empty); end
   endtask

   task automatic test_random();
      logic wr, rd, rst;
      int   sz;
      for (int i = 0; i < 600; i++) begin
         wr  = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 70 : 35));
         rd  = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 35 : 70));
         rst = ($urandom_range(127) == 0);
         cycle(wr, rd, 8'($urandom), rst);
         sz = model_q.size();
         n_cmp++; if (o_rddata !== model_rd) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", i, o_rddata, model_rd); end
         n_cmp++; if ({o_full, o_empty, o_alm_full, o_alm_empty} !== {sz == DP, sz == 0, sz >= 14, sz <= 2}) begin
            n_err++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {o_full, o_empty, o_alm_full, o_alm_empty},
                              {sz == DP, sz == 0, sz >= 14, sz <= 2});
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      i_wren   = 1'b0;
      i_rden   = 1'b0;
      i_wrdata = 8'h00;
      model_rd = 8'h00;
      test_reset();
      test_fill();
      test_overflow_drain();
      test_read_empty();
      test_back_to_back();
      test_full_simul();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
